// File: rtl/huffmanencode.sv
// huffmanencode
// Canonical JPEG Huffman encoder. Given one 8-bit symbol and a DHT table
// (16 code-length counts plus up to 256 symbols in canonical order), it walks
// the table one entry per clock, rebuilding the canonical code as it goes, and
// reports the codeword of the first entry that matches the symbol.
//
// Ports
//   clk          rising-edge clock
//   huffrst      asynchronous active-high reset
//   start        encode request, sampled only while idle
//   symbol       symbol to encode, captured on the accepting edge
//   hufftable    byte k = number of codes of length k+1 (k = 0..15)
//   huffsymbol   byte i = symbol at canonical index i
//   huffcode     codeword, right-aligned
//   huffcodemsb  codeword, left-aligned in a 16-bit window
//   hufflength   code length 1..16, 0 on a miss
//   hufffinish   one-cycle pulse when the result registers are updated
//   huffmiss     symbol not present in the table (valid with hufffinish)
//   busy         high while the table walk is in progress
module huffmanencode (
    input  logic          clk,
    input  logic          huffrst,
    input  logic          start,
    input  logic [7:0]    symbol,
    input  logic [127:0]  hufftable,
    input  logic [2047:0] huffsymbol,
    output logic [15:0]   huffcode,
    output logic [15:0]   huffcodemsb,
    output logic [7:0]    hufflength,
    output logic          hufffinish,
    output logic          huffmiss,
    output logic          busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  sym, sym_nxt;
    logic [4:0]  len, len_nxt;
    logic [15:0] code, code_nxt;
    logic [8:0]  index, index_nxt;
    logic [7:0]  remaining, remaining_nxt;

    logic [15:0] rescode_nxt, resmsb_nxt;
    logic [7:0]  reslen_nxt;
    logic        finish_nxt, miss_nxt;

    logic [7:0]  candidate;
    logic [7:0]  nextcount;

    // Table entry under the walk pointer, and the count for the next length.
    // len is 1-based, so byte len of hufftable holds the count for len+1.
    assign candidate = huffsymbol[{index[7:0], 3'b000} +: 8];
    assign nextcount = hufftable[{len[3:0], 3'b000} +: 8];

    assign busy = (state == SCAN);

    // Next-state and datapath: one table step per clock while scanning.
    // A length is exhausted when remaining hits zero; the code is then
    // doubled before the first code of the next length is issued.
    always_comb begin
        state_nxt     = state;
        sym_nxt       = sym;
        len_nxt       = len;
        code_nxt      = code;
        index_nxt     = index;
        remaining_nxt = remaining;
        rescode_nxt   = huffcode;
        resmsb_nxt    = huffcodemsb;
        reslen_nxt    = hufflength;
        miss_nxt      = huffmiss;
        finish_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sym_nxt       = symbol;
                    len_nxt       = 5'd1;
                    code_nxt      = 16'd0;
                    index_nxt     = 9'd0;
                    remaining_nxt = hufftable[7:0];
                    state_nxt     = SCAN;
                end
            end

            SCAN: begin
                if (remaining == 8'd0) begin
                    if (len < 5'd16) begin
                        len_nxt       = len + 5'd1;
                        code_nxt      = code << 1;
                        remaining_nxt = nextcount;
                    end else begin
                        state_nxt   = IDLE;
                        finish_nxt  = 1'b1;
                        miss_nxt    = 1'b1;
                        rescode_nxt = 16'd0;
                        resmsb_nxt  = 16'd0;
                        reslen_nxt  = 8'd0;
                    end
                end else if (index[8]) begin
                    // Walked past the last possible entry without a hit.
                    state_nxt   = IDLE;
                    finish_nxt  = 1'b1;
                    miss_nxt    = 1'b1;
                    rescode_nxt = 16'd0;
                    resmsb_nxt  = 16'd0;
                    reslen_nxt  = 8'd0;
                end else if (candidate == sym) begin
                    state_nxt   = IDLE;
                    finish_nxt  = 1'b1;
                    miss_nxt    = 1'b0;
                    rescode_nxt = code;
                    resmsb_nxt  = code << (5'd16 - len);
                    reslen_nxt  = {3'b000, len};
                end else begin
                    code_nxt      = code + 16'd1;
                    index_nxt     = index + 9'd1;
                    remaining_nxt = remaining - 8'd1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, walk registers and held result registers.
    always_ff @(posedge clk or posedge huffrst) begin
        if (huffrst) begin
            state       <= IDLE;
            sym         <= 8'd0;
            len         <= 5'd0;
            code        <= 16'd0;
            index       <= 9'd0;
            remaining   <= 8'd0;
            huffcode    <= 16'd0;
            huffcodemsb <= 16'd0;
            hufflength  <= 8'd0;
            hufffinish  <= 1'b0;
            huffmiss    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sym         <= sym_nxt;
            len         <= len_nxt;
            code        <= code_nxt;
            index       <= index_nxt;
            remaining   <= remaining_nxt;
            huffcode    <= rescode_nxt;
            huffcodemsb <= resmsb_nxt;
            hufflength  <= reslen_nxt;
            hufffinish  <= finish_nxt;
            huffmiss    <= miss_nxt;
        end
    end

endmodule

// File: doc/huffmanencode.md
# huffmanencode

Canonical JPEG Huffman encoder and the transmit-side counterpart of `huffmandecode`. It takes one 8-bit symbol plus a DHT table in the same packed form the decoder uses: 16 code-length counts and up to 256 symbols in order. It walks the table sequentially to build the canonical code and returns the codeword and its length. It sits in the entropy-coding path ahead of the bit packer, and its MSB-aligned output drops straight into the decoder's 16-bit `code` window for loopback checks.

## Interface
- No parameters; table widths are fixed by the JPEG DHT format.
- `clk` in 1: rising-edge clock.
- `huffrst` in 1: asynchronous, active-high reset.
- `start` in 1: request to encode `symbol`; sampled only in IDLE.
- `symbol` in 8: symbol to encode; captured on the accepting edge.
- `hufftable` in 128: byte k (`[8k+7:8k]`) is the number of codes of length k+1, for k = 0..15.
- `huffsymbol` in 2048: byte i is the symbol at canonical index i.
- `huffcode` out 16: codeword, right-aligned, upper bits zero.
- `huffcodemsb` out 16: codeword left-aligned (`huffcode << (16-hufflength)`), zero-filled below.
- `hufflength` out 8: code length, 1..16; 0 on miss.
- `hufffinish` out 1: one-cycle pulse when a result is valid.
- `huffmiss` out 1: valid with `hufffinish`; symbol is not in the table.
- `busy` out 1: high while SCAN.

## Operation
- States: IDLE, SCAN.
- IDLE, `start`=1 at an edge:
  - capture `symbol`;
  - set length L=1, code=0, index=0, remaining=`hufftable` byte 0;
  - go to SCAN.
- SCAN, one step per clock:
  - **remaining==0 and L<16:** L++, code<<=1, remaining=count[L]. This is an advance step.
  - **remaining==0 and L==16:** miss; finish.
  - **remaining>0, `huffsymbol`[index]==captured symbol:** hit; finish with `huffcode`=code, `hufflength`=L.
  - **remaining>0, no match:** code++, index++, remaining--.
  - **index reaches 256 without a hit:** miss.
- Finish:
  - outputs are registered on the same edge;
  - `hufffinish`=1 for exactly one cycle;
  - state returns to IDLE.
- On a miss, `huffcode`, `huffcodemsb` and `hufflength` are all 0.
- Outputs hold their last result until the next finish or a reset.
- The first matching index wins if a symbol appears twice.
- Code arithmetic is 16-bit, and the shift happens before the next length's codes are issued.
- Behaviour is defined only for valid DHT tables (Kraft-compliant, total count ≤256). Tables and symbol are not re-sampled during SCAN; the caller holds `hufftable`/`huffsymbol` stable while `busy`.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, `busy`=0, `hufffinish`=0, `huffmiss`=0;
  - `huffcode`, `huffcodemsb`, `hufflength` = 0.
  - A reset during SCAN discards the request; no `hufffinish` follows.
- Latency: `start` is accepted at edge E0; `hufffinish` rises after edge E0+N, where N is the number of SCAN steps:
  - hit: advance steps + index + 1;
  - miss: advance steps + entries scanned + 1.
- `busy` is high from after E0 until the finishing edge. It is low in the `hufffinish` cycle.
- A `start` asserted during SCAN is ignored, not queued.
- A `start` asserted in the `hufffinish` cycle is accepted, because the block is in IDLE. This allows back-to-back encodes with no bubble beyond the pulse.

## Test plan
Stimulus for the first five scenarios is the standard luminance AC table:
- counts: 0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125;
- symbols: 1,2,3,0,4,17,…,250 (162 entries).

Scenarios:
- **Symbol 2:** `huffcode`=0x0001, `hufflength`=2, `huffcodemsb`=0x4000, `huffmiss`=0, `hufffinish` after N=3 edges.
- **Symbols 1, 3, 0, 17, back-to-back** (each `start` asserted in the previous `hufffinish` cycle):
  - 1 → code 0b00, len 2;
  - 3 → 0b100, len 3;
  - 0 → 0b1010, len 4;
  - 17 → 0b1100, len 4.
  - Exactly four `hufffinish` pulses.
- **Symbol 250 (last entry):** `huffcode`=0xFFFE, `hufflength`=16, N=177.
- **Symbol 11 (absent):** `huffmiss`=1, `hufflength`=0, `huffcode`=0, N=178.
- **Reset during SCAN:** assert `huffrst` mid-scan while encoding 250 → `busy`=0 immediately and all outputs 0. No `hufffinish` appears; a new encode of 2 then completes normally.
- **Loopback:** encode symbols 2, 3, 1 and concatenate the `huffcodemsb` bits into a 16-bit `code`. Feed that word, with the same table, into `huffmandecode` → decoded symbols 2, 3, 1 with lengths 2, 3, 2.
